// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the memory-mapped responder.
//   - Register offsets inside the 4 KiB window (address[11:0]).
//   - access_size encodings.
//   - Bit positions of the fields in the STATUS register.
package mmio_pkg;

    // Register offsets
    localparam logic [11:0] OFF_TIME_LO = 12'h000;
    localparam logic [11:0] OFF_TIME_HI = 12'h004;
    localparam logic [11:0] OFF_CMP_LO  = 12'h008;
    localparam logic [11:0] OFF_CMP_HI  = 12'h00C;
    localparam logic [11:0] OFF_TX_DATA = 12'h010;
    localparam logic [11:0] OFF_STATUS  = 12'h014;

    // access_size encodings (3 behaves as a word)
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // STATUS fields
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 9;

    // Word-sized access: encodings 2 and 3.
    function automatic logic is_word_size(input logic [1:0] sz);
        return (sz == SZ_WORD) || (sz == 2'd3);
    endfunction

endpackage

// File: rtl/mmio_responder_byte_fifo.sv
// byte_fifo: small byte-wide FIFO feeding the console transmitter.
//   clock, reset   : posedge clock, synchronous active-high reset
//   push/push_data : enqueue request and byte
//   pop            : dequeue request (ignored while empty)
//   head           : current front byte, 0 while empty
//   empty/full     : occupancy flags
//   count          : number of stored bytes, 0..DEPTH
// A push while full is accepted only when a pop happens on the same edge;
// the popped slot is the one the push overwrites, so ordering is preserved.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = 1;
    localparam logic [AW:0]   COUNT_ONE  = 1;
    localparam logic [AW:0]   COUNT_FULL = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == COUNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Forced to zero while empty so tx_data reads 0 out of reset.
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    // Storage carries no reset; a slot is always written before it is read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped peripheral on the data-memory port.
//   clock, reset        : posedge clock, synchronous active-high reset
//   address, data_in    : byte address and write data from the memory stage
//   read_write          : 1 = write, 0 = read
//   access_size         : 0 byte, 1 half, 2/3 word
//   hit                 : address lies in the 4 KiB window at BASE
//   data_out            : combinational read data (0 on a miss)
//   tx_data, tx_valid   : console FIFO head and non-empty flag
//   tx_ready            : sink accepts the head this cycle
//   timer_irq           : registered time >= cmp
// Console handshake: a byte transfers on a clock edge where tx_valid and
// tx_ready are both high; tx_data/tx_valid change only on edges and the head
// byte holds steady while tx_valid is high and tx_ready is low.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0200_0000,
    parameter int          DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        read_write,
    input  logic [1:0]  access_size,
    output logic        hit,
    output logic [31:0] data_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [11:0]   offset;
    logic          wr_en;
    logic          word_wr;
    logic          tx_push;
    logic          tx_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          overrun;
    logic [31:0]   status_word;

    logic [63:0]   time_q;
    logic [63:0]   cmp_q;
    logic          overflow_q;
    logic          irq_q;

    assign offset   = address[11:0];
    assign hit      = (address[31:12] == BASE[31:12]);
    assign wr_en    = hit && read_write;
    // Only word-sized, word-aligned writes reach the 32-bit registers.
    assign word_wr  = wr_en && is_word_size(access_size) && (offset[1:0] == 2'b00);
    // TX_DATA takes any size anywhere inside its word.
    assign tx_push  = wr_en && (offset[11:2] == OFF_TX_DATA[11:2]);
    assign tx_valid = !fifo_empty;
    assign tx_pop   = tx_valid && tx_ready;
    // A push into a full FIFO is lost unless a pop frees the slot this edge.
    assign overrun  = tx_push && fifo_full && !tx_pop;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (data_in[7:0]),
        .pop       (tx_pop),
        .head      (tx_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        status_word = '0;
        status_word[ST_EMPTY]    = fifo_empty;
        status_word[ST_FULL]     = fifo_full;
        status_word[ST_OVERFLOW] = overflow_q;
        status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
    end

    always_comb begin
        data_out = '0;
        if (hit) begin
            case (offset)
                OFF_TIME_LO: data_out = time_q[31:0];
                OFF_TIME_HI: data_out = time_q[63:32];
                OFF_CMP_LO:  data_out = cmp_q[31:0];
                OFF_CMP_HI:  data_out = cmp_q[63:32];
                OFF_STATUS:  data_out = status_word;
                default:     data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            time_q     <= '0;
            cmp_q      <= '1;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            time_q <= time_q + 64'd1;
            // Compare uses the pre-edge time and cmp.
            irq_q  <= (time_q >= cmp_q);

            if (word_wr && (offset == OFF_CMP_LO)) begin
                cmp_q[31:0] <= data_in;
            end
            if (word_wr && (offset == OFF_CMP_HI)) begin
                cmp_q[63:32] <= data_in;
            end

            // A new overrun wins over a same-cycle clear.
            if (overrun) begin
                overflow_q <= 1'b1;
            end else if (word_wr && (offset == OFF_STATUS) && data_in[ST_OVERFLOW]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign timer_irq = irq_q;

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;
    import mmio_pkg::*;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        read_write;
    logic [1:0]  access_size;
    logic        hit;
    logic [31:0] data_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    mmio_responder #(.BASE(BASE), .DEPTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .data_in     (data_in),
        .read_write  (read_write),
        .access_size (access_size),
        .hit         (hit),
        .data_out    (data_out),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .timer_irq   (timer_irq)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_e;
    logic [63:0] m_time;
    logic        rdy_sel;

    // Bench-side cycle counter: counts edges since the last reset edge.
    always @(posedge clock) begin
        if (reset) m_time <= '0;
        else       m_time <= m_time + 64'd1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time-out expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: every accepted console byte must match the queue front.
    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_byte", {56'b0, tx_data}, {56'b0, mon_e});
            end
        end
    end

    // ---------------- drivers ----------------
    // One bus cycle: drive after the edge, return at the following negedge
    // where combinational outputs are sampled.
    task automatic cyc(input logic [31:0] a, input logic rw, input logic [1:0] sz,
                       input logic [31:0] d);
        @(posedge clock);
        #1;
        address     = a;
        read_write  = rw;
        access_size = sz;
        data_in     = d;
        tx_ready    = rdy_sel;
        @(negedge clock);
    endtask

    task automatic idle();
        cyc(32'h0, 1'b0, SZ_WORD, 32'h0);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic expect_accept);
        cyc(BASE + 32'(OFF_TX_DATA), 1'b1, SZ_BYTE, {24'hEEEEEE, b});
        if (expect_accept) exp_q.push_back(b);
    endtask

    task automatic do_reset(input int n);
        @(posedge clock);
        #1;
        reset      = 1'b1;
        address    = 32'h0;
        read_write = 1'b0;
        rdy_sel    = 1'b0;
        tx_ready   = 1'b0;
        exp_q.delete();
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        rdy_sel = 1'b1;
        while (tx_valid && k < budget) begin
            idle();
            k++;
        end
        rdy_sel = 1'b0;
        check("drain_done_valid", {63'b0, tx_valid}, 64'd0);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [1:0]  sz;
        logic [31:0] wdata;
        logic        exp_hit;
        logic        chk_data;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] t0;
        logic [63:0] rise_t;

        reset = 1'b1; address = '0; data_in = '0; read_write = 1'b0;
        access_size = SZ_WORD; tx_ready = 1'b0; rdy_sel = 1'b0;

        vecs.push_back('{BASE + 32'h014, 1'b0, SZ_WORD, 32'h0,          1'b1, 1'b1, 32'h0000_0001, "rst_status"});
        vecs.push_back('{BASE + 32'h008, 1'b0, SZ_WORD, 32'h0,          1'b1, 1'b1, 32'hFFFF_FFFF, "rst_cmp_lo"});
        vecs.push_back('{BASE + 32'h00C, 1'b0, SZ_BYTE, 32'h0,          1'b1, 1'b1, 32'hFFFF_FFFF, "rst_cmp_hi_byte_read"});
        vecs.push_back('{BASE + 32'h010, 1'b0, SZ_WORD, 32'h0,          1'b1, 1'b1, 32'h0,         "tx_data_read_zero"});
        vecs.push_back('{BASE + 32'h018, 1'b0, SZ_WORD, 32'h0,          1'b1, 1'b1, 32'h0,         "unmapped_read"});
        vecs.push_back('{BASE + 32'hFFC, 1'b0, SZ_WORD, 32'h0,          1'b1, 1'b1, 32'h0,         "window_top_read"});
        vecs.push_back('{BASE + 32'h1008, 1'b0, SZ_WORD, 32'h0,         1'b0, 1'b1, 32'h0,         "miss_read"});
        vecs.push_back('{BASE + 32'h008, 1'b1, SZ_HALF, 32'h0000_1234,  1'b1, 1'b0, 32'h0,         "half_wr_cmp_lo"});
        vecs.push_back('{BASE + 32'h1008, 1'b1, SZ_WORD, 32'h0000_0055, 1'b0, 1'b1, 32'h0,         "miss_wr"});
        vecs.push_back('{BASE + 32'h009, 1'b1, SZ_WORD, 32'h0,          1'b1, 1'b0, 32'h0,         "misaligned_wr"});
        vecs.push_back('{BASE + 32'h008, 1'b0, SZ_WORD, 32'h0,          1'b1, 1'b1, 32'hFFFF_FFFF, "cmp_lo_unchanged"});
        vecs.push_back('{BASE + 32'h014, 1'b1, SZ_WORD, 32'hFFFF_FFFB,  1'b1, 1'b0, 32'h0,         "status_ro_wr"});
        vecs.push_back('{BASE + 32'h014, 1'b0, SZ_WORD, 32'h0,          1'b1, 1'b1, 32'h0000_0001, "status_unchanged"});

        // ---- reset state ----
        do_reset(3);
        check("rst_tx_valid", {63'b0, tx_valid}, 64'd0);
        check("rst_tx_data", {56'b0, tx_data}, 64'd0);
        check("rst_timer_irq", {63'b0, timer_irq}, 64'd0);
        repeat (4) idle();
        cyc(BASE + 32'(OFF_TIME_LO), 1'b0, SZ_WORD, 32'h0);
        check("time_lo_after_5", {32'b0, data_out}, 64'd5);
        cyc(BASE + 32'(OFF_TIME_HI), 1'b0, SZ_WORD, 32'h0);
        check("time_hi", {32'b0, data_out}, 64'd0);

        // ---- table: reads, decode, ignored writes ----
        foreach (vecs[i]) begin
            cyc(vecs[i].addr, vecs[i].rw, vecs[i].sz, vecs[i].wdata);
            check({vecs[i].name, "_hit"}, {63'b0, hit}, {63'b0, vecs[i].exp_hit});
            if (vecs[i].chk_data)
                check(vecs[i].name, {32'b0, data_out}, {32'b0, vecs[i].exp_data});
        end
        check("no_push_from_table", {63'b0, tx_valid}, 64'd0);

        // ---- TX drain ----
        rdy_sel = 1'b0;
        push_byte(8'h41, 1'b1);
        check("push_empty_valid_not_yet", {63'b0, tx_valid}, 64'd0);
        cyc(BASE + 32'h013, 1'b1, SZ_HALF, 32'hABCD_0042);
        exp_q.push_back(8'h42);
        cyc(BASE + 32'(OFF_STATUS), 1'b0, SZ_WORD, 32'h0);
        check("status_two", {32'b0, data_out}, 64'h0000_0200);
        check("head_41", {56'b0, tx_data}, 64'h41);
        check("valid_two", {63'b0, tx_valid}, 64'd1);
        idle();
        check("head_hold_41", {56'b0, tx_data}, 64'h41);
        rdy_sel = 1'b1;
        idle();
        idle();
        check("head_42", {56'b0, tx_data}, 64'h42);
        rdy_sel = 1'b0;
        idle();
        check("drained_valid", {63'b0, tx_valid}, 64'd0);
        check("drained_queue", 64'(exp_q.size()), 64'd0);

        // ---- overflow ----
        for (int b = 1; b <= 9; b++) push_byte(8'(b), b <= 8);
        cyc(BASE + 32'(OFF_STATUS), 1'b0, SZ_WORD, 32'h0);
        check("status_overflow", {32'b0, data_out}, 64'h0000_0806);
        cyc(BASE + 32'(OFF_STATUS), 1'b1, SZ_WORD, 32'h0000_0004);
        cyc(BASE + 32'(OFF_STATUS), 1'b0, SZ_WORD, 32'h0);
        check("status_ovf_cleared", {32'b0, data_out}, 64'h0000_0802);
        drain(20);

        // ---- full with simultaneous pop ----
        for (int b = 0; b < 8; b++) push_byte(8'h10 + 8'(b), 1'b1);
        rdy_sel = 1'b1;
        push_byte(8'h5A, 1'b1);
        rdy_sel = 1'b0;
        cyc(BASE + 32'(OFF_STATUS), 1'b0, SZ_WORD, 32'h0);
        check("status_full_pop", {32'b0, data_out}, 64'h0000_0802);
        drain(20);

        // ---- timer ----
        cyc(BASE + 32'(OFF_CMP_HI), 1'b1, SZ_WORD, 32'h0);
        @(posedge clock);
        #1;
        t0 = m_time;
        address = BASE + 32'(OFF_CMP_LO); read_write = 1'b1; access_size = SZ_WORD;
        data_in = t0[31:0] + 32'd10; tx_ready = 1'b0;
        @(negedge clock);
        check("irq_low_before", {63'b0, timer_irq}, 64'd0);
        rise_t = '0;
        for (int k = 0; k < 40; k++) begin
            idle();
            if (timer_irq) begin
                rise_t = m_time;
                break;
            end
        end
        check("irq_rise_time", rise_t, t0 + 64'd11);
        cyc(BASE + 32'(OFF_CMP_HI), 1'b1, SZ_WORD, 32'hFFFF_FFFF);
        idle();
        check("irq_hold_one_edge", {63'b0, timer_irq}, 64'd1);
        idle();
        check("irq_fall_two_edges", {63'b0, timer_irq}, 64'd0);

        // ---- reset mid-drain ----
        for (int b = 0; b < 3; b++) push_byte(8'hC0 + 8'(b), 1'b1);
        rdy_sel = 1'b1;
        idle();
        do_reset(1);
        address = BASE + 32'(OFF_TIME_LO); read_write = 1'b0; access_size = SZ_WORD;
        @(negedge clock);
        check("mid_rst_tx_valid", {63'b0, tx_valid}, 64'd0);
        check("mid_rst_time_lo", {32'b0, data_out}, 64'd0);
        cyc(BASE + 32'(OFF_STATUS), 1'b0, SZ_WORD, 32'h0);
        check("mid_rst_status", {32'b0, data_out}, 64'h0000_0001);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
